cache_arbiter: RTL and testbench

// - Shares one physical-memory / cacheline-adaptor port between the I-cache and D-cache miss paths.
// - Grants one 256-bit line transaction at a time and steers data/resp to the granted cache.
// - Sits between the two caches and the cacheline adaptor.
// - Keeps per-requester wait-cycle performance counters.

---
 rtl/cache_arbiter_if.sv | 42 ++++
 rtl/cache_arbiter.sv | 115 +++++++++++
 tb/tb_cache_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Bus bundle joining the I-cache and D-cache miss paths, the arbiter and the shared memory port.
// The master modport is the arbiter's view; the slave modport is the caches/memory side.
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256
);
    logic                  i_pmem_read;
    logic [31:0]           i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [31:0]           d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one cacheline memory port between the I-cache and D-cache miss paths, with wait counters.
// Define ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise D has fixed priority.
//
// state   | meaning
// IDLE    | no transaction; grant on any pending request
// SERVE_I | I-cache line read in flight on the memory port
// SERVE_D | D-cache read or writeback in flight on the memory port
// DONE    | single dead cycle so the finished cache can drop its request
module cache_arbiter #(
    parameter int LINE_WIDTH    = 256,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_arbiter_if.master          bus,
    output logic [COUNTER_WIDTH-1:0] i_wait_count,
    output logic [COUNTER_WIDTH-1:0] d_wait_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    logic   d_req;
    logic   grant_d;

    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_grant_d;

    // On a tie, hand the port to whoever did not get it last time.
    assign grant_d = d_req & (~bus.i_pmem_read | ~last_grant_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_grant_d <= 1'b1;
            end else if (bus.i_pmem_read) begin
                last_grant_d <= 1'b0;
            end
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // A simultaneous read and write means writeback before fill.
                        bus.pmem_address <= bus.d_pmem_address;
                        bus.pmem_wdata   <= bus.d_pmem_wdata;
                        bus.pmem_write   <= bus.d_pmem_write;
                        bus.pmem_read    <= ~bus.d_pmem_write;
                        state            <= SERVE_D;
                    end else if (bus.i_pmem_read) begin
                        bus.pmem_address <= bus.i_pmem_address;
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_read    <= 1'b1;
                        state            <= SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        bus.pmem_read  <= 1'b0;
                        bus.pmem_write <= 1'b0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response and data pass straight through to the granted cache only.
    assign bus.i_pmem_resp  = (state == SERVE_I) & bus.pmem_resp;
    assign bus.d_pmem_resp  = (state == SERVE_D) & bus.pmem_resp;
    assign bus.i_pmem_rdata = bus.i_pmem_resp ? bus.pmem_rdata : '0;
    assign bus.d_pmem_rdata = bus.d_pmem_resp ? bus.pmem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_wait_count <= '0;
            d_wait_count <= '0;
        end else begin
            if (bus.i_pmem_read && (state != SERVE_I) && (i_wait_count != '1)) begin
                i_wait_count <= i_wait_count + COUNTER_WIDTH'(1);
            end
            if (d_req && (state != SERVE_D) && (d_wait_count != '1)) begin
                d_wait_count <= d_wait_count + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single fills, writeback, contention, arbitration order,
// async reset mid-transaction and wait-counter saturation on a narrow-counter instance.
module tb_cache_arbiter;

    logic clk;
    logic rst;
    logic [31:0] i_wait_count;
    logic [31:0] d_wait_count;
    logic [3:0]  i_wait_count4;
    logic [3:0]  d_wait_count4;

    int n_checks;
    int n_fail;

    cache_arbiter_if #(.LINE_WIDTH(256)) bus ();
    cache_arbiter_if #(.LINE_WIDTH(256)) bus4 ();

    cache_arbiter #(.LINE_WIDTH(256), .COUNTER_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .i_wait_count (i_wait_count),
        .d_wait_count (d_wait_count)
    );

    cache_arbiter #(.LINE_WIDTH(256), .COUNTER_WIDTH(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus4.master),
        .i_wait_count (i_wait_count4),
        .d_wait_count (d_wait_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

    logic [255:0] pattern_a5;
    logic [255:0] pattern_wd;
    logic [255:0] pattern_d3;
    logic [31:0]  grants [4];
    logic [31:0]  exp_grants [4];
    int           cnt;
    int           ng;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        pattern_a5 = {32{8'hA5}};
        pattern_wd = {8{32'h1234_5678}};
        pattern_d3 = {16{16'hD00D}};
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_grants = '{32'h200, 32'h300, 32'h200, 32'h300};
`else
        exp_grants = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
        rst = 1'b1;
        bus.i_pmem_read = 0;  bus.i_pmem_address = '0;
        bus.d_pmem_read = 0;  bus.d_pmem_write = 0;
        bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
        bus.pmem_rdata = '0;  bus.pmem_resp = 0;
        bus4.i_pmem_read = 0; bus4.i_pmem_address = 32'h40;
        bus4.d_pmem_read = 0; bus4.d_pmem_write = 0;
        bus4.d_pmem_address = 32'h80; bus4.d_pmem_wdata = '0;
        bus4.pmem_rdata = '0; bus4.pmem_resp = 0;

        // Reset state
        @(negedge clk); #1;
        check_eq("rst_pmem_read", bus.pmem_read, 0);
        check_eq("rst_pmem_write", bus.pmem_write, 0);
        check_eq("rst_pmem_address", bus.pmem_address, 0);
        check_eq("rst_pmem_wdata", bus.pmem_wdata, 0);
        check_eq("rst_i_resp", bus.i_pmem_resp, 0);
        check_eq("rst_d_resp", bus.d_pmem_resp, 0);
        check_eq("rst_i_wait", i_wait_count, 0);
        check_eq("rst_d_wait", d_wait_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // I-cache fill, response on the 5th cycle of pmem_read
        @(negedge clk);
        bus.i_pmem_read = 1; bus.i_pmem_address = 32'h60;
        @(negedge clk); #1;
        check_eq("i_fill_pmem_read", bus.pmem_read, 1);
        check_eq("i_fill_pmem_write", bus.pmem_write, 0);
        check_eq("i_fill_address", bus.pmem_address, 32'h60);
        check_eq("i_fill_wait_idle", i_wait_count, 1);
        repeat (3) @(negedge clk);
        #1 check_eq("i_fill_no_early_resp", bus.i_pmem_resp, 0);
        @(negedge clk);
        bus.pmem_resp = 1; bus.pmem_rdata = pattern_a5;
        #1;
        check_eq("i_fill_resp", bus.i_pmem_resp, 1);
        check_eq("i_fill_rdata", bus.i_pmem_rdata, pattern_a5);
        check_eq("i_fill_d_resp_quiet", bus.d_pmem_resp, 0);
        check_eq("i_fill_d_rdata_zero", bus.d_pmem_rdata, 0);
        @(negedge clk);
        bus.pmem_resp = 0; bus.pmem_rdata = '0; bus.i_pmem_read = 0;
        #1;
        check_eq("i_fill_done_read_low", bus.pmem_read, 0);
        check_eq("i_fill_resp_single", bus.i_pmem_resp, 0);
        @(negedge clk); #1;
        check_eq("i_fill_idle_read_low", bus.pmem_read, 0);
        check_eq("i_fill_wait_final", i_wait_count, 1);

        // D-cache writeback, 3-cycle memory latency
        @(negedge clk);
        bus.d_pmem_write = 1; bus.d_pmem_address = 32'h100; bus.d_pmem_wdata = pattern_wd;
        @(negedge clk); #1;
        check_eq("d_wb_pmem_write", bus.pmem_write, 1);
        check_eq("d_wb_pmem_read", bus.pmem_read, 0);
        check_eq("d_wb_address", bus.pmem_address, 32'h100);
        check_eq("d_wb_wdata", bus.pmem_wdata, pattern_wd);
        @(negedge clk); #1;
        check_eq("d_wb_write_held", bus.pmem_write, 1);
        @(negedge clk);
        bus.pmem_resp = 1;
        #1;
        check_eq("d_wb_resp", bus.d_pmem_resp, 1);
        check_eq("d_wb_i_resp_quiet", bus.i_pmem_resp, 0);
        @(negedge clk);
        bus.pmem_resp = 0; bus.d_pmem_write = 0;
        #1 check_eq("d_wb_done_write_low", bus.pmem_write, 0);
        @(negedge clk); #1;
        check_eq("d_wb_idle_write_low", bus.pmem_write, 0);
        check_eq("d_wb_wait", d_wait_count, 1);

        // Simultaneous I and D reads, 3-cycle latency: D first, then I
        do_reset();
        @(negedge clk);
        bus.i_pmem_read = 1; bus.i_pmem_address = 32'h80;
        bus.d_pmem_read = 1; bus.d_pmem_address = 32'h140;
        @(negedge clk); #1;
        check_eq("tie_d_granted_addr", bus.pmem_address, 32'h140);
        check_eq("tie_d_read", bus.pmem_read, 1);
        @(negedge clk);
        @(negedge clk);
        bus.pmem_resp = 1; bus.pmem_rdata = pattern_d3;
        #1;
        check_eq("tie_d_resp", bus.d_pmem_resp, 1);
        check_eq("tie_d_rdata", bus.d_pmem_rdata, pattern_d3);
        check_eq("tie_i_resp_quiet", bus.i_pmem_resp, 0);
        check_eq("tie_i_rdata_zero", bus.i_pmem_rdata, 0);
        @(negedge clk);
        bus.pmem_resp = 0; bus.pmem_rdata = '0; bus.d_pmem_read = 0;
        #1 check_eq("tie_done_no_grant", bus.pmem_read, 0);
        @(negedge clk); #1;
        check_eq("tie_idle_no_grant", bus.pmem_read, 0);
        @(negedge clk); #1;
        check_eq("tie_i_granted_read", bus.pmem_read, 1);
        check_eq("tie_i_granted_addr", bus.pmem_address, 32'h80);
        check_eq("tie_i_wait_at_grant", i_wait_count, 6);
        check_eq("tie_d_wait", d_wait_count, 1);
        @(negedge clk);
        @(negedge clk);
        bus.pmem_resp = 1;
        #1 check_eq("tie_i_resp", bus.i_pmem_resp, 1);
        @(negedge clk);
        bus.pmem_resp = 0; bus.i_pmem_read = 0;
        @(negedge clk); #1;
        check_eq("tie_i_wait_final", i_wait_count, 6);

        // Both requesters held continuously: record four grant addresses
        do_reset();
        @(negedge clk);
        bus.i_pmem_read = 1; bus.i_pmem_address = 32'h300;
        bus.d_pmem_read = 1; bus.d_pmem_address = 32'h200;
        cnt = 0;
        ng  = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            bus.pmem_resp = 0;
            if (bus.pmem_read) begin
                cnt++;
                if (cnt == 1) begin
                    grants[ng] = bus.pmem_address;
                    ng++;
                end
                if (cnt == 2) begin
                    bus.pmem_resp = 1;
                    cnt = 0;
                end
            end
        end
        bus.pmem_resp = 0;
        bus.i_pmem_read = 0; bus.d_pmem_read = 0;
        check_eq("arb_grant_count", ng, 4);
        for (int g = 0; g < 4; g++) begin
            if (g < ng) check_eq($sformatf("arb_grant_%0d", g), grants[g], exp_grants[g]);
        end

        // Async reset in the middle of a D writeback
        do_reset();
        @(negedge clk);
        bus.d_pmem_write = 1; bus.d_pmem_address = 32'h180; bus.d_pmem_wdata = pattern_wd;
        @(negedge clk); #1;
        check_eq("rst_mid_write_before", bus.pmem_write, 1);
        check_eq("rst_mid_d_wait_before", d_wait_count, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_write_dropped", bus.pmem_write, 0);
        check_eq("rst_mid_d_wait_cleared", d_wait_count, 0);
        @(negedge clk);
        rst = 1'b0; bus.d_pmem_write = 0;
        @(negedge clk);
        bus.pmem_resp = 1;
        #1;
        check_eq("rst_stray_d_resp", bus.d_pmem_resp, 0);
        check_eq("rst_stray_i_resp", bus.i_pmem_resp, 0);
        @(negedge clk);
        bus.pmem_resp = 0;
        #1 check_eq("rst_idle_write_low", bus.pmem_write, 0);

        // Narrow counter: I starved behind a D read that never completes
        @(negedge clk);
        bus4.i_pmem_read = 1; bus4.d_pmem_read = 1;
        repeat (10) @(negedge clk);
        #1 check_eq("sat_i_wait_10", i_wait_count4, 10);
        repeat (10) @(negedge clk);
        #1;
        check_eq("sat_i_wait_20", i_wait_count4, 15);
        check_eq("sat_d_wait", d_wait_count4, 1);
        check_eq("sat_d_served_addr", bus4.pmem_address, 32'h80);
        bus4.i_pmem_read = 0; bus4.d_pmem_read = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
